// File: rtl/meteor_spawn_scheduler.sv
// meteor_spawn_scheduler: frame-paced spawner that claims the lowest free meteor slot
// and offers a clamped random spawn command over a valid/ready handshake.
module meteor_spawn_scheduler #(
  parameter int N_SLOTS       = 8,
  parameter int BASE_INTERVAL = 60,
  parameter int LEVEL_STEP    = 8,
  parameter int MIN_INTERVAL  = 8,
  parameter int SCREEN_W      = 640
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       enable,
  input  logic                       frame_tick,
  input  logic [2:0]                 level,
  input  logic [9:0]                 rand_pos,
  input  logic [2:0]                 rand_xspd,
  input  logic [2:0]                 rand_yspd,
  input  logic                       rand_sign,
  input  logic [N_SLOTS-1:0]         slot_release,
  input  logic                       spawn_ready,
  output logic                       spawn_valid,
  output logic [$clog2(N_SLOTS)-1:0] spawn_slot,
  output logic [9:0]                 spawn_pos,
  output logic [2:0]                 spawn_xspd,
  output logic [2:0]                 spawn_yspd,
  output logic                       spawn_sign,
  output logic [N_SLOTS-1:0]         slot_busy,
  output logic [$clog2(N_SLOTS):0]   active_count,
  output logic [7:0]                 missed_spawns
);
  localparam int SW = $clog2(N_SLOTS);
  localparam int CW = SW + 1;
  typedef enum logic [1:0] {IDLE, WAIT, ARB, OFFER} state_e;
  state_e state_q, state_d;
  logic [15:0] frame_cnt_q, frame_cnt_d, interval, step_frames;
  logic [N_SLOTS-1:0] busy_q, busy_d;
  logic [7:0] missed_q, missed_d;
  logic [SW-1:0] slot_q, slot_d, free_idx;
  logic [9:0] pos_q, pos_d;
  logic [2:0] xspd_q, xspd_d, yspd_q, yspd_d;
  logic sign_q, sign_d;
  assign step_frames = 16'(level) * 16'(LEVEL_STEP);
  assign interval = (16'(BASE_INTERVAL) > step_frames + 16'(MIN_INTERVAL)) ?
                    16'(BASE_INTERVAL) - step_frames : 16'(MIN_INTERVAL);
  // Scan downward so the lowest free index is the last one written.
  always_comb begin
    free_idx = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) if (!busy_q[i]) free_idx = SW'(i);
  end
  always_comb begin
    active_count = '0;
    for (int i = 0; i < N_SLOTS; i++) active_count = active_count + CW'(busy_q[i]);
  end
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    missed_d    = missed_q;
    slot_d      = slot_q;
    pos_d       = pos_q;
    xspd_d      = xspd_q;
    yspd_d      = yspd_q;
    sign_d      = sign_q;
    busy_d      = busy_q & ~slot_release;
    case (state_q)
      IDLE: begin
        frame_cnt_d = '0;
        state_d     = enable ? WAIT : IDLE;
      end
      WAIT: begin
        if (!enable) state_d = IDLE;
        else if (frame_tick) begin
          state_d     = (frame_cnt_q == interval - 16'd1) ? ARB : WAIT;
          frame_cnt_d = (frame_cnt_q == interval - 16'd1) ? '0 : frame_cnt_q + 16'd1;
        end
      end
      ARB: begin
        if (!enable) state_d = IDLE;
        else if (~&busy_q) begin
          state_d = OFFER;
          slot_d  = free_idx;
          pos_d   = (rand_pos >= 10'(SCREEN_W)) ? rand_pos - 10'(SCREEN_W) : rand_pos;
          xspd_d  = (rand_xspd == 3'd0) ? 3'd1 : rand_xspd;
          yspd_d  = (rand_yspd == 3'd0) ? 3'd1 : rand_yspd;
          sign_d  = rand_sign;
        end else begin
          state_d  = WAIT;
          missed_d = missed_q + 8'(missed_q != 8'hFF);
        end
      end
      OFFER: begin
        if (spawn_ready) begin
          busy_d[slot_q] = 1'b1;
          state_d        = enable ? WAIT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      busy_q      <= '0;
      missed_q    <= '0;
      slot_q      <= '0;
      pos_q       <= '0;
      xspd_q      <= '0;
      yspd_q      <= '0;
      sign_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      busy_q      <= busy_d;
      missed_q    <= missed_d;
      slot_q      <= slot_d;
      pos_q       <= pos_d;
      xspd_q      <= xspd_d;
      yspd_q      <= yspd_d;
      sign_q      <= sign_d;
    end
  end
  assign spawn_valid   = (state_q == OFFER);
  assign spawn_slot    = slot_q;
  assign spawn_pos     = pos_q;
  assign spawn_xspd    = xspd_q;
  assign spawn_yspd    = yspd_q;
  assign spawn_sign    = sign_q;
  assign slot_busy     = busy_q;
  assign missed_spawns = missed_q;
endmodule
